// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, rx state encodings and baud divisor helper
`timescale 1ns/1ps
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser with a caller-chosen reset value
`timescale 1ns/1ps
module uart_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // metastability filter: d -> meta -> q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10000000,
  parameter int BAUDRATE = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;
  logic                 half_tc;
  logic                 bit_tc;
  uart_sync2 #(.W(1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (1'b1),
    .d       (rx_in),
    .q       (rx_s)
  );
  assign half_tc = clk_cnt == CW'(HALF_BIT - 1);
  assign bit_tc  = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign busy    = state != S_IDLE;
  // frame FSM: qualify start at half bit, then sample each bit one full period later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          state   <= rx_s ? S_IDLE : S_START;
        end
        S_START: begin
          clk_cnt <= half_tc ? '0 : clk_cnt + CW'(1);
          bit_idx <= '0;
          state   <= !half_tc ? S_START : rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          clk_cnt <= bit_tc ? '0 : clk_cnt + CW'(1);
          if (bit_tc) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            state          <= bit_idx == 3'd7 ? S_STOP : S_DATA;
          end
        end
        S_STOP: begin
          clk_cnt <= bit_tc ? '0 : clk_cnt + CW'(1);
          if (bit_tc) begin
            done      <= rx_s;
            frame_err <= !rx_s;
            state     <= rx_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: state <= rx_s ? S_IDLE : S_BREAK;
        default: state <= S_IDLE;
      endcase
    end
  end
  // output register: load on completion unless a held byte is not being taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (!done && rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT_NS = 8680;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] got[$];
  int         vcyc = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  time        first_v = 0;
  time        t_start = 0;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_valid;
    int         n_ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && first_v == 0) first_v = $time;
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    got.delete();
    vcyc = 0;
    ferr_cnt = 0;
    ovr_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #BIT_NS;
    end
    rx_in = stop;
    #BIT_NS;
  endtask

  initial begin
    vecs[0] = '{8'h61, 1'b1, 1, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 1};
    vecs[2] = '{8'h12, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1, 0};
    vecs[4] = '{8'hC3, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    #320;
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    chk("rst_ovr", {31'd0, overrun}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1000;
    for (int v = 0; v < 6; v++) begin
      clear();
      first_v = 0;
      t_start = $time;
      send_frame(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        #(20 * BIT_NS);
        chk($sformatf("v%0d_busy_break", v), {31'd0, busy}, 32'h1);
        rx_in = 1'b1;
      end
      #BIT_NS;
      chk($sformatf("v%0d_nvalid", v), got.size(), vecs[v].n_valid);
      chk($sformatf("v%0d_vcyc", v), vcyc, vecs[v].n_valid);
      chk($sformatf("v%0d_nferr", v), ferr_cnt, vecs[v].n_ferr);
      chk($sformatf("v%0d_novr", v), ovr_cnt, 0);
      if (vecs[v].n_valid == 1 && got.size() == 1) chk($sformatf("v%0d_data", v), {24'd0, got[0]}, {24'd0, vecs[v].data});
      if (v == 0) chk("latency_window", {31'd0, (first_v - t_start) > 81000 && (first_v - t_start) < 84000}, 32'h1);
      chk($sformatf("v%0d_busy_idle", v), {31'd0, busy}, 32'h0);
    end
    clear();
    send_frame(8'h00, 1'b1);
    chk("b2b_busy_gap0", {31'd0, busy}, 32'h0);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    #(2 * BIT_NS);
    chk("b2b_count", got.size(), 3);
    chk("b2b_vcyc", vcyc, 3);
    if (got.size() == 3) begin
      chk("b2b_d0", {24'd0, got[0]}, 32'h00);
      chk("b2b_d1", {24'd0, got[1]}, 32'hFF);
      chk("b2b_d2", {24'd0, got[2]}, 32'hA5);
    end
    clear();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    #BIT_NS;
    chk("ovr_first_valid", {31'd0, rx_valid}, 32'h1);
    send_frame(8'hC3, 1'b1);
    #BIT_NS;
    chk("ovr_valid_held", {31'd0, rx_valid}, 32'h1);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
    chk("ovr_pulses", ovr_cnt, 1);
    rx_ready = 1'b1;
    #300;
    chk("ovr_accept_valid", {31'd0, rx_valid}, 32'h0);
    chk("ovr_accept_count", got.size(), 1);
    if (got.size() == 1) chk("ovr_accept_data", {24'd0, got[0]}, 32'h3C);
    clear();
    rx_in = 1'b0;
    #2000;
    chk("glitch_busy", {31'd0, busy}, 32'h1);
    rx_in = 1'b1;
    #30000;
    chk("glitch_idle", {31'd0, busy}, 32'h0);
    chk("glitch_novalid", got.size(), 0);
    chk("glitch_noferr", ferr_cnt, 0);
    clear();
    rx_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      #BIT_NS;
    end
    rx_in = 1'b1;
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #20;
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    #480;
    rst_n = 1'b1;
    #BIT_NS;
    send_frame(8'h81, 1'b1);
    #BIT_NS;
    chk("mid_rst_count", got.size(), 1);
    chk("mid_rst_ferr", ferr_cnt, 0);
    chk("mid_rst_ovr", ovr_cnt, 0);
    if (got.size() == 1) chk("mid_rst_data", {24'd0, got[0]}, 32'h81);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
